mac_stg4_acc: RTL and testbench

Parametrised final MAC stage. Sums NUM_PSUM extended partial sums in one adder tree, optionally accumulates over a multi-beat group, and normalises the result to sign / leading-one mantissa / shift amount for the output formatter. It sits between the stage-3 partial-sum producers and the output format stage. It supersedes the fixed two-input, single-beat final stage, adding a global stall and saturation.

---
 rtl/mac_stg4_acc_pkg.sv | 31 +++
 rtl/mac_lzd_norm.sv | 46 ++++
 rtl/mac_stg4_acc.sv | 239 +++++++++++++++++++++++
 tb/tb_mac_stg4_acc.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_stg4_acc_pkg.sv
// Shared definitions for the final MAC stage: width helpers and lane slicing.
`ifndef MAC_STG4_ACC_PKG_SV
`define MAC_STG4_ACC_PKG_SV

// Select lane IDX (W bits wide) out of a packed lane bus; lane 0 sits in the LSBs.
`define MAC_LANE(bus, idx, w) bus[(idx)*(w) +: (w)]

package mac_stg4_acc_pkg;

    // Ceiling log2, used to size the adder-tree growth.
    function automatic int clog2_f(input int v);
        return $clog2(v);
    endfunction

    // Accumulator width: lane width, tree growth and guard bits.
    function automatic int acc_w_f(input int psum_w, input int num_psum, input int acc_ext);
        return psum_w + clog2_f(num_psum) + acc_ext;
    endfunction

    // Reference bit position of the leading one for a zero shift.
    function automatic int r_f(input int psum_w);
        return psum_w - 2;
    endfunction

    localparam int DEF_PSUM_W   = 19;
    localparam int DEF_NUM_PSUM = 2;
    localparam int DEF_ACC_EXT  = 4;

endpackage

`endif

// File: rtl/mac_lzd_norm.sv
// Combinational leading-one detect and normalise of an unsigned magnitude.
module mac_lzd_norm #(
    parameter int ACC_W   = 24,
    parameter int NORM_W  = 11,
    parameter int SHIFT_W = 5,
    parameter int R       = 17
) (
    input  logic [ACC_W-1:0]   mag_i,
    output logic [NORM_W-1:0]  norm_o,
    output logic [SHIFT_W-1:0] exp_diff_o,
    output logic               exp_carry_o,
    output logic               zero_o
);

    localparam int PW = $clog2(ACC_W);

    logic [PW-1:0] lead;

    // Leading-one position: the highest set bit wins since later iterations overwrite.
    always_comb begin
        lead = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag_i[i]) lead = PW'(i);
        end
    end

    // Align the leading one to the mantissa MSB and derive the shift direction/amount.
    always_comb begin
        zero_o      = (mag_i == '0);
        norm_o      = NORM_W'({mag_i, {(NORM_W-1){1'b0}}} >> lead);
        exp_carry_o = 1'b0;
        exp_diff_o  = '0;
        if (int'(lead) > R) begin
            exp_carry_o = 1'b1;
            exp_diff_o  = SHIFT_W'(int'(lead) - R);
        end else begin
            exp_diff_o  = SHIFT_W'(R - int'(lead));
        end
        if (zero_o) begin
            norm_o      = '0;
            exp_diff_o  = '0;
            exp_carry_o = 1'b0;
        end
    end

endmodule

// File: rtl/mac_stg4_acc.sv
// Final MAC stage: lane adder tree, group accumulator with saturation, normaliser.
//
// Handshake: a beat is taken when i_valid=1 and i_inhibit=0 at a rising edge; there
// is no backpressure. o_valid marks a new result only on an edge where i_inhibit=0;
// under i_inhibit every stage, including o_valid, simply holds.
module mac_stg4_acc
    import mac_stg4_acc_pkg::*;
#(
    parameter int NUM_PSUM = 2,
    parameter int PSUM_W   = 19,
    parameter int ACC_EXT  = 4,
    parameter int EXP_W    = 6,
    parameter int NORM_W   = 11,
    parameter int SHIFT_W  = 5,
    parameter int Q_W      = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic                       i_inhibit,
    input  logic                       i_acc_en,
    input  logic                       i_acc_first,
    input  logic                       i_acc_last,
    input  logic [NUM_PSUM*PSUM_W-1:0] i_psum,
    input  logic [EXP_W-1:0]           i_max_exp,
    input  logic [Q_W-1:0]             i_Q_frac,
    output logic                       o_valid,
    output logic [EXP_W-1:0]           o_max_exp,
    output logic [Q_W-1:0]             o_Q_frac,
    output logic [NORM_W-1:0]          o_norm_sum,
    output logic [SHIFT_W-1:0]         o_exp_diff,
    output logic                       o_exp_carry,
    output logic                       o_sgn,
    output logic                       o_zero,
    output logic                       o_sat,
    output logic                       o_err
);

    localparam int ACC_W = acc_w_f(PSUM_W, NUM_PSUM, ACC_EXT);
    localparam int R     = r_f(PSUM_W);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // S1 input register
    logic                       s1_valid_q;
    logic                       s1_acc_en_q;
    logic                       s1_first_q;
    logic                       s1_last_q;
    logic [NUM_PSUM*PSUM_W-1:0] s1_psum_q;
    logic [EXP_W-1:0]           s1_exp_q;
    logic [Q_W-1:0]             s1_qf_q;

    // S2 accumulator state
    logic [ACC_W-1:0] acc_q,  acc_d;
    logic             open_q, open_d;
    logic             sat_q,  sat_d;
    logic [EXP_W-1:0] exp_q,  exp_d;
    logic [Q_W-1:0]   qf_q,   qf_d;
    logic             done_q, done_d;
    logic             err_q,  err_d;

    // S3 output register
    logic               out_valid_q;
    logic [EXP_W-1:0]   out_exp_q;
    logic [Q_W-1:0]     out_qf_q;
    logic [NORM_W-1:0]  out_norm_q;
    logic [SHIFT_W-1:0] out_diff_q;
    logic               out_carry_q;
    logic               out_sgn_q;
    logic               out_zero_q;
    logic               out_sat_q;

    logic [ACC_W-1:0] tree;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] sat_sum;
    logic             ovf;
    logic             beat_first;

    logic               res_sgn;
    logic [ACC_W-1:0]   res_mag;
    logic [NORM_W-1:0]  nrm_norm;
    logic [SHIFT_W-1:0] nrm_diff;
    logic               nrm_carry;
    logic               nrm_zero;

    // S1: capture the incoming beat unless stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q  <= 1'b0;
            s1_acc_en_q <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_psum_q   <= '0;
            s1_exp_q    <= '0;
            s1_qf_q     <= '0;
        end else if (!i_inhibit) begin
            s1_valid_q  <= i_valid;
            s1_acc_en_q <= i_acc_en;
            s1_first_q  <= i_acc_first;
            s1_last_q   <= i_acc_last;
            s1_psum_q   <= i_psum;
            s1_exp_q    <= i_max_exp;
            s1_qf_q     <= i_Q_frac;
        end
    end

    // Adder tree: sign-extend every lane to the accumulator width and sum.
    always_comb begin
        logic [PSUM_W-1:0] ln;
        tree = '0;
        for (int l = 0; l < NUM_PSUM; l++) begin
            ln   = `MAC_LANE(s1_psum_q, l, PSUM_W);
            tree = tree + {{(ACC_W-PSUM_W){ln[PSUM_W-1]}}, ln};
        end
    end

    // Saturating accumulate: overflow shows as disagreement of the two top sum bits.
    always_comb begin
        sum_ext = {acc_q[ACC_W-1], acc_q} + {tree[ACC_W-1], tree};
        ovf     = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
        sat_sum = sum_ext[ACC_W-1:0];
        if (ovf) sat_sum = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end

    // S2 next state: group open/close, first-beat capture, sticky protocol error.
    always_comb begin
        acc_d      = acc_q;
        open_d     = open_q;
        sat_d      = sat_q;
        exp_d      = exp_q;
        qf_d       = qf_q;
        done_d     = 1'b0;
        err_d      = err_q;
        beat_first = 1'b0;
        if (s1_valid_q) begin
            if (!s1_acc_en_q) begin
                acc_d  = tree;
                sat_d  = 1'b0;
                exp_d  = s1_exp_q;
                qf_d   = s1_qf_q;
                open_d = 1'b0;
                done_d = 1'b1;
            end else begin
                beat_first = s1_first_q || !open_q;
                if (s1_first_q && open_q) err_d = 1'b1;
                if (beat_first) begin
                    acc_d = tree;
                    sat_d = 1'b0;
                    exp_d = s1_exp_q;
                    qf_d  = s1_qf_q;
                end else begin
                    acc_d = sat_sum;
                    sat_d = sat_q | ovf;
                end
                done_d = s1_last_q;
                open_d = !s1_last_q;
            end
        end
    end

    // S2 register update, frozen under stall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q  <= '0;
            open_q <= 1'b0;
            sat_q  <= 1'b0;
            exp_q  <= '0;
            qf_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (!i_inhibit) begin
            acc_q  <= acc_d;
            open_q <= open_d;
            sat_q  <= sat_d;
            exp_q  <= exp_d;
            qf_q   <= qf_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // Sign and magnitude; the most negative value maps to 2^(ACC_W-1) unsigned.
    always_comb begin
        res_sgn = acc_q[ACC_W-1];
        res_mag = res_sgn ? -acc_q : acc_q;
    end

    mac_lzd_norm #(
        .ACC_W  (ACC_W),
        .NORM_W (NORM_W),
        .SHIFT_W(SHIFT_W),
        .R      (R)
    ) u_norm (
        .mag_i      (res_mag),
        .norm_o     (nrm_norm),
        .exp_diff_o (nrm_diff),
        .exp_carry_o(nrm_carry),
        .zero_o     (nrm_zero)
    );

    // S3: publish a completed group; outputs hold between results and under stall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_q <= 1'b0;
            out_exp_q   <= '0;
            out_qf_q    <= '0;
            out_norm_q  <= '0;
            out_diff_q  <= '0;
            out_carry_q <= 1'b0;
            out_sgn_q   <= 1'b0;
            out_zero_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else if (!i_inhibit) begin
            out_valid_q <= done_q;
            if (done_q) begin
                out_exp_q   <= exp_q;
                out_qf_q    <= qf_q;
                out_norm_q  <= nrm_norm;
                out_diff_q  <= nrm_diff;
                out_carry_q <= nrm_carry;
                out_sgn_q   <= res_sgn & ~nrm_zero;
                out_zero_q  <= nrm_zero;
                out_sat_q   <= sat_q;
            end
        end
    end

    assign o_valid     = out_valid_q;
    assign o_max_exp   = out_exp_q;
    assign o_Q_frac    = out_qf_q;
    assign o_norm_sum  = out_norm_q;
    assign o_exp_diff  = out_diff_q;
    assign o_exp_carry = out_carry_q;
    assign o_sgn       = out_sgn_q;
    assign o_zero      = out_zero_q;
    assign o_sat       = out_sat_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_mac_stg4_acc.sv
// Bench for mac_stg4_acc: directed cases plus random beats against a value-level model.
module tb_mac_stg4_acc;

  localparam int NUM_PSUM = 2;
  localparam int PSUM_W   = 19;
  localparam int EXP_W    = 6;
  localparam int NORM_W   = 11;
  localparam int SHIFT_W  = 5;
  localparam int Q_W      = 5;
  localparam int R        = 17;
  localparam longint ACC_MAX = (longint'(1) <<< 23) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< 23);

  typedef struct packed {
    logic [31:0]        cyc;
    logic [EXP_W-1:0]   max_exp;
    logic [Q_W-1:0]     q;
    logic [NORM_W-1:0]  norm;
    logic [SHIFT_W-1:0] diff;
    logic               carry;
    logic               sgn;
    logic               zero;
    logic               sat;
  } exp_t;
  localparam int EW = $bits(exp_t);

  // clock / reset / DUT
  logic                       clk = 1'b0;
  logic                       i_rst, i_valid, i_inhibit, i_acc_en, i_acc_first, i_acc_last;
  logic [NUM_PSUM*PSUM_W-1:0] i_psum;
  logic [EXP_W-1:0]           i_max_exp, o_max_exp;
  logic [Q_W-1:0]             i_Q_frac, o_Q_frac;
  logic                       o_valid, o_exp_carry, o_sgn, o_zero, o_sat, o_err;
  logic [NORM_W-1:0]          o_norm_sum;
  logic [SHIFT_W-1:0]         o_exp_diff;

  always #5 clk = ~clk;

  mac_stg4_acc dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_inhibit(i_inhibit),
    .i_acc_en(i_acc_en), .i_acc_first(i_acc_first), .i_acc_last(i_acc_last),
    .i_psum(i_psum), .i_max_exp(i_max_exp), .i_Q_frac(i_Q_frac),
    .o_valid(o_valid), .o_max_exp(o_max_exp), .o_Q_frac(o_Q_frac),
    .o_norm_sum(o_norm_sum), .o_exp_diff(o_exp_diff), .o_exp_carry(o_exp_carry),
    .o_sgn(o_sgn), .o_zero(o_zero), .o_sat(o_sat), .o_err(o_err)
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int act_cnt = 0;
  logic inh_prev = 1'b0;

  // reference model state: one open group at most
  logic   m_open = 1'b0;
  logic   m_err  = 1'b0;
  logic   m_sat  = 1'b0;
  longint m_acc  = 0;
  int     m_exp  = 0;
  int     m_q    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected output fields of a group, straight from its signed total.
  function automatic exp_t mk_exp(input longint acc, input logic sat, input int me, input int mq,
                                  input int cyc);
    exp_t e;
    longint mag;
    int p;
    e = '0;
    e.cyc = 32'(cyc);
    e.max_exp = EXP_W'(me);
    e.q = Q_W'(mq);
    e.sat = sat;
    mag = (acc < 0) ? -acc : acc;
    if (mag == 0) begin
      e.zero = 1'b1;
    end else begin
      p = 0;
      while ((mag >> (p + 1)) != 0) p++;
      e.sgn = (acc < 0);
      if (p > R) begin
        e.carry = 1'b1;
        e.diff = SHIFT_W'(p - R);
      end else begin
        e.diff = SHIFT_W'(R - p);
      end
      if (p >= NORM_W - 1) e.norm = NORM_W'(mag >> (p - (NORM_W - 1)));
      else                 e.norm = NORM_W'(mag << (NORM_W - 1 - p));
    end
    return e;
  endfunction

  // Apply one accepted beat to the model; results appear 2 unstalled edges later.
  task automatic model_beat(input logic en, input logic first, input logic last,
                            input int p0, input int p1, input int me, input int mq);
    longint tree;
    int cyc;
    tree = longint'(p0) + longint'(p1);
    cyc  = act_cnt + 3;
    if (!en) begin
      exp_q.push_back(mk_exp(tree, 1'b0, me, mq, cyc));
      m_open = 1'b0;
    end else begin
      if (first && m_open) m_err = 1'b1;
      if (first || !m_open) begin
        m_acc = tree; m_sat = 1'b0; m_exp = me; m_q = mq;
      end else begin
        m_acc = m_acc + tree;
        if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_sat = 1'b1; end
        if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_sat = 1'b1; end
      end
      if (last) begin
        exp_q.push_back(mk_exp(m_acc, m_sat, m_exp, m_q, cyc));
        m_open = 1'b0;
      end else begin
        m_open = 1'b1;
      end
    end
  endtask

  // driver tasks
  task automatic beat(input logic en, input logic first, input logic last,
                      input int p0, input int p1, input int me, input int mq);
    i_valid = 1'b1; i_acc_en = en; i_acc_first = first; i_acc_last = last;
    i_psum = {PSUM_W'(p1), PSUM_W'(p0)};
    i_max_exp = EXP_W'(me); i_Q_frac = Q_W'(mq);
    @(posedge clk);
    if (!i_inhibit && !i_rst) model_beat(en, first, last, p0, p1, me, mq);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_psum = {PSUM_W'($urandom), PSUM_W'($urandom)};
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stall with a junk single-beat group on the inputs; it must be ignored.
  task automatic stall(input int n);
    i_inhibit = 1'b1; i_valid = 1'b1; i_acc_en = 1'b1; i_acc_first = 1'b1; i_acc_last = 1'b1;
    i_psum = {PSUM_W'($urandom), PSUM_W'($urandom)};
    repeat (n) @(posedge clk);
    #1;
    i_inhibit = 1'b0; i_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1; i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    i_rst = 1'b0;
    m_open = 1'b0; m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_max_exp"}, o_max_exp, 0);
    chk({tag, "_q_frac"}, o_Q_frac, 0);
    chk({tag, "_norm"}, o_norm_sum, 0);
    chk({tag, "_diff"}, o_exp_diff, 0);
    chk({tag, "_carry"}, o_exp_carry, 0);
    chk({tag, "_sgn"}, o_sgn, 0);
    chk({tag, "_zero"}, o_zero, 0);
    chk({tag, "_sat"}, o_sat, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  function automatic int rnd_psum();
    int v;
    if ($urandom_range(0, 1) == 0) begin
      v = int'($urandom_range(0, 2000)) - 1000;
    end else begin
      v = int'($urandom_range(0, (1 << PSUM_W) - 1));
      if (v >= (1 << (PSUM_W - 1))) v = v - (1 << PSUM_W);
    end
    return v;
  endfunction

  // count unstalled edges; remember whether the last edge was stalled
  always @(posedge clk) begin
    if (!i_inhibit) act_cnt <= act_cnt + 1;
    inh_prev <= i_inhibit;
  end

  // monitor: a new result is o_valid after an unstalled edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!i_rst && o_valid && !inh_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("latency", act_cnt, e.cyc);
        chk("max_exp", o_max_exp, e.max_exp);
        chk("q_frac", o_Q_frac, e.q);
        chk("norm_sum", o_norm_sum, e.norm);
        chk("exp_diff", o_exp_diff, e.diff);
        chk("exp_carry", o_exp_carry, e.carry);
        chk("sgn", o_sgn, e.sgn);
        chk("zero", o_zero, e.zero);
        chk("sat", o_sat, e.sat);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_inhibit = 1'b0; i_acc_en = 1'b0;
    i_acc_first = 1'b0; i_acc_last = 1'b0; i_psum = '0; i_max_exp = '0; i_Q_frac = '0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // single-beat groups
    beat(1'b0, 1'b0, 1'b0, 256, 256, 3, 1);
    idle(3);
    beat(1'b0, 1'b0, 1'b0, -3, 0, 4, 2);
    idle(3);

    // four-beat group, max_exp/Q_frac from beat 1 only
    beat(1'b1, 1'b1, 1'b0, 65536, 65536, 7, 5);
    for (int i = 0; i < 2; i++) beat(1'b1, 1'b0, 1'b0, 65536, 65536, 20 + i, 9 + i);
    beat(1'b1, 1'b0, 1'b1, 65536, 65536, 30, 12);
    idle(3);

    // saturating 17-beat group
    beat(1'b1, 1'b1, 1'b0, 262143, 262143, 11, 3);
    for (int i = 0; i < 15; i++) beat(1'b1, 1'b0, 1'b0, 262143, 262143, 1, 1);
    beat(1'b1, 1'b0, 1'b1, 262143, 262143, 1, 1);
    idle(3);

    // most negative saturation
    beat(1'b1, 1'b1, 1'b0, -262144, -262144, 13, 6);
    for (int i = 0; i < 16; i++) beat(1'b1, 1'b0, 1'b0, -262144, -262144, 0, 0);
    beat(1'b1, 1'b0, 1'b1, -262144, -262144, 0, 0);
    idle(3);

    // zero result, then first-on-open-group error
    beat(1'b0, 1'b0, 1'b0, 5, -5, 2, 2);
    idle(3);
    chk("err_before", o_err, m_err);
    beat(1'b1, 1'b1, 1'b0, 100, 200, 5, 5);
    beat(1'b1, 1'b1, 1'b0, 300, 400, 6, 6);
    beat(1'b1, 1'b0, 1'b1, 10, 20, 7, 7);
    idle(3);
    chk("err_set", o_err, m_err);
    beat(1'b0, 1'b0, 1'b0, 77, 88, 1, 1);
    idle(3);
    chk("err_sticky", o_err, m_err);

    // four-beat group with a 3-cycle stall in the middle
    beat(1'b1, 1'b1, 1'b0, 65536, 65536, 7, 5);
    beat(1'b1, 1'b0, 1'b0, 65536, 65536, 21, 9);
    stall(3);
    beat(1'b1, 1'b0, 1'b0, 65536, 65536, 22, 10);
    beat(1'b1, 1'b0, 1'b1, 65536, 65536, 30, 12);
    idle(1);
    stall(2);
    idle(4);

    // random traffic with occasional stalls
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 0) stall(int'($urandom_range(1, 3)));
      else if (r == 1) idle(1);
      else beat($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                rnd_psum(), rnd_psum(), int'($urandom_range(0, 63)), int'($urandom_range(0, 31)));
    end
    idle(4);
    chk("err_random", o_err, m_err);
    chk("drain_random", exp_q.size(), 0);

    // reset in the middle of an open group
    beat(1'b1, 1'b1, 1'b0, 1234, 4321, 9, 9);
    beat(1'b1, 1'b0, 1'b0, 1234, 4321, 9, 9);
    do_reset(2);
    @(negedge clk);
    chk_all_zero("midreset");
    beat(1'b1, 1'b0, 1'b0, 1000, 2000, 17, 4);
    beat(1'b1, 1'b0, 1'b1, -500, 250, 18, 5);
    idle(4);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
